// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and WB payload packing for pipe_stage_reg
//
// Purpose : payload width and field offsets of the MEM->WB payload, default
//           counter width, and a helper that packs the WB fields into one bus.
// Ports   : none (package).
// Config  : none.
package pipe_pkg;

    localparam int PIPE_DATA_W_WB = 104;
    localparam int PIPE_CNT_W     = 16;

    // WB payload layout, LSB first: rd_wr_en, rd_addr, pc4, lsu, alu, wb_sel.
    localparam int WREN_BIT   = 0;
    localparam int RD_LSB     = 1;
    localparam int PC4_LSB    = 6;
    localparam int LSU_LSB    = 38;
    localparam int ALU_LSB    = 70;
    localparam int WB_SEL_LSB = 102;

    function automatic logic [PIPE_DATA_W_WB-1:0] pack_wb(
        input logic [1:0]  wb_sel,
        input logic [31:0] alu,
        input logic [31:0] lsu,
        input logic [31:0] pc4,
        input logic [4:0]  rd_addr,
        input logic        rd_wr_en
    );
        return {wb_sel, alu, lsu, pc4, rd_addr, rd_wr_en};
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter
//
// Purpose : counts cycles with inc=1, sticks at all-ones, cleared only by rst.
// Ports   : clk, rst (sync, active-high), inc -> cnt[CNT_W-1:0].
// Config  : none.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with handshake, flush and stall/flush counters
//
// Purpose : registers an opaque DATA_W payload between two pipeline stages
//           with valid/ready flow control, flush, and saturating counters.
// Ports   : clk, rst (sync, active-high)
//           upstream   : in_valid, in_ready, in_data[DATA_W-1:0]
//           control    : flush
//           downstream : out_valid, out_ready, out_data[DATA_W-1:0]
//           counters   : stall_cnt[CNT_W-1:0], flush_cnt[CNT_W-1:0]
// Config  : PIPE_SKID_EN - adds a second (skid) entry and registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = PIPE_DATA_W_WB,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic accept;
    logic stall;
    logic flush_hit;

    assign accept = in_valid & in_ready;
    assign stall  = out_valid & ~out_ready;

`ifdef PIPE_SKID_EN
    logic              drain;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    assign drain     = out_valid & out_ready;
    // Registered ready: upstream never sees a combinational path from out_ready.
    assign in_ready  = ~skid_valid;
    // One flush counts once even when both entries are occupied.
    assign flush_hit = flush & (out_valid | skid_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= RST_VAL;
            skid_valid <= 1'b0;
            skid_data  <= RST_VAL;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // Skid full means in_ready=0, so only a drain can move things.
            if (drain) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (stall) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end else begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign in_ready  = ~out_valid | out_ready;
    assign flush_hit = flush & out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (flush) begin
            // Payload is left stale; consumers qualify it with out_valid.
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (accept) begin
                out_data <= in_data;
            end
        end
    end
`endif

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_hit),
        .cnt (flush_cnt)
    );

endmodule
